// File: rtl/lsu_arbiter.sv
// Round-robin arbiter and sequencer sharing the LSU address/store port between
// the core data port (m0) and the debug/DMA port (m1).
module lsu_arbiter #(
  parameter logic [31:0] IDLE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_req_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic        m0_we_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic        m1_we_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] lsu_addr_o,
  output logic [31:0] lsu_st_data_o,
  output logic        lsu_st_en_o,
  input  logic [31:0] lsu_ld_data_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      r_state;
  state_e      w_next;
  logic        r_lastWinner;
  logic        r_id;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        w_anyReq;
  logic        w_capture;
  logic        w_winner;
  logic [31:0] w_respData;

  assign w_anyReq  = m0_req_i | m1_req_i;
  assign w_capture = ((r_state == IDLE) || (r_state == RESP)) && w_anyReq;

  // m1 wins when it is the only requester, or when both ask and m0 won last
  assign w_winner  = m1_req_i & (~m0_req_i | ~r_lastWinner);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_lastWinner <= 1'b1;
      r_id         <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_id         <= w_winner;
        r_lastWinner <= w_winner;
        r_we         <= w_winner ? m1_we_i    : m0_we_i;
        r_addr       <= w_winner ? m1_addr_i  : m0_addr_i;
        r_wdata      <= w_winner ? m1_wdata_i : m0_wdata_i;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_anyReq ? ACCESS : IDLE;
      ACCESS:  w_next = RESP;
      RESP:    w_next = w_anyReq ? ACCESS : IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_respData = r_we ? 32'h0 : lsu_ld_data_i;

  // The LSU sees a safe data-memory address and no store outside ACCESS
  always_comb begin
    m0_gnt_o      = 1'b0;
    m1_gnt_o      = 1'b0;
    m0_rvalid_o   = 1'b0;
    m1_rvalid_o   = 1'b0;
    m0_rdata_o    = 32'h0;
    m1_rdata_o    = 32'h0;
    lsu_addr_o    = IDLE_ADDR;
    lsu_st_data_o = 32'h0;
    lsu_st_en_o   = 1'b0;
    busy_o        = 1'b0;
    case (r_state)
      ACCESS: begin
        busy_o        = 1'b1;
        lsu_addr_o    = r_addr;
        lsu_st_data_o = r_wdata;
        lsu_st_en_o   = r_we;
        m0_gnt_o      = ~r_id;
        m1_gnt_o      = r_id;
      end
      RESP: begin
        busy_o = 1'b1;
        if (r_id) begin
          m1_rvalid_o = 1'b1;
          m1_rdata_o  = w_respData;
        end else begin
          m0_rvalid_o = 1'b1;
          m0_rdata_o  = w_respData;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Scoreboard bench for lsu_arbiter with a small registered-load LSU model
// holding a word memory and the io_ledr register at 0x880.
module tb_lsu_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_i, m1_req_i;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic        m0_we_i, m1_we_i;
  logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic [31:0] lsu_addr_o, lsu_st_data_o, lsu_ld_data_i;
  logic        lsu_st_en_o, busy_o;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          nChecks = 0;
  int          nFails  = 0;
  logic [31:0] mem [0:255];
  logic [31:0] ioLedr;
  bit          memReady = 1'b0;

  always #5 clk_i = ~clk_i;

  lsu_arbiter #(.IDLE_ADDR(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_we_i(m0_we_i),
    .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_we_i(m1_we_i),
    .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .lsu_addr_o(lsu_addr_o), .lsu_st_data_o(lsu_st_data_o), .lsu_st_en_o(lsu_st_en_o),
    .lsu_ld_data_i(lsu_ld_data_i), .busy_o(busy_o)
  );

  // LSU model: store on the edge, load data registered one cycle after the address
  always @(posedge clk_i) begin
    if (!memReady) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + i;
      mem[4]   <= 32'hDEAD_BEEF;
      mem[8]   <= 32'h1234_5678;
      mem[16]  <= 32'h0000_4040;
      mem[17]  <= 32'h0000_4444;
      ioLedr   <= 32'h0;
      memReady <= 1'b1;
    end else begin
      if (lsu_st_en_o) begin
        if (lsu_addr_o == 32'h880) ioLedr <= lsu_st_data_o;
        else mem[lsu_addr_o[9:2]] <= lsu_st_data_o;
      end
      lsu_ld_data_i <= (lsu_addr_o == 32'h880) ? ioLedr : mem[lsu_addr_o[9:2]];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit port, input logic req, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic we);
    if (port) begin
      m1_req_i = req; m1_addr_i = addr; m1_wdata_i = wdata; m1_we_i = we;
    end else begin
      m0_req_i = req; m0_addr_i = addr; m0_wdata_i = wdata; m0_we_i = we;
    end
  endtask

  // Monitor: pops one expected response per rvalid, independent of the stimulus
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1) begin
      checkOutput("gnt_rvalid_excl", {31'h0, (m0_gnt_o | m1_gnt_o) & (m0_rvalid_o | m1_rvalid_o)}, 32'h0);
      if (m0_rvalid_o || m1_rvalid_o) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_rvalid", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("resp_port", {30'h0, m1_rvalid_o, m0_rvalid_o}, e.port ? 32'h2 : 32'h1);
          checkOutput("resp_data", e.port ? m1_rdata_o : m0_rdata_o, e.data);
          checkOutput("loser_rdata", e.port ? m0_rdata_o : m1_rdata_o, 32'h0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int          cyc;
    int          nG;
    bit          gPort [0:3];
    int          gCyc  [0:3];
    int          g0;
    int          raiseCyc;
    int          m1GntCyc;
    bit          raised;

    rst_ni = 1'b0;
    applyStimulus(0, 0, 32'h0, 32'h0, 0);
    applyStimulus(1, 0, 32'h0, 32'h0, 0);
    repeat (2) @(negedge clk_i);

    checkOutput("rst_busy",    {31'h0, busy_o}, 32'h0);
    checkOutput("rst_gnt",     {30'h0, m1_gnt_o, m0_gnt_o}, 32'h0);
    checkOutput("rst_rvalid",  {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
    checkOutput("rst_rdata0",  m0_rdata_o, 32'h0);
    checkOutput("rst_rdata1",  m1_rdata_o, 32'h0);
    checkOutput("rst_addr",    lsu_addr_o, 32'h0);
    checkOutput("rst_st_en",   {31'h0, lsu_st_en_o}, 32'h0);
    checkOutput("rst_st_data", lsu_st_data_o, 32'h0);
    rst_ni = 1'b1;

    // m0 load from 0x10
    applyStimulus(0, 1, 32'h10, 32'h0, 0);
    sb.push_back('{port: 1'b0, data: 32'hDEAD_BEEF});
    @(negedge clk_i);
    checkOutput("ld_gnt0",  {31'h0, m0_gnt_o}, 32'h1);
    checkOutput("ld_gnt1",  {31'h0, m1_gnt_o}, 32'h0);
    checkOutput("ld_addr",  lsu_addr_o, 32'h10);
    checkOutput("ld_st_en", {31'h0, lsu_st_en_o}, 32'h0);
    checkOutput("ld_busy",  {31'h0, busy_o}, 32'h1);
    applyStimulus(0, 0, 32'h10, 32'h0, 0);
    @(negedge clk_i);
    checkOutput("ld_gnt_once", {31'h0, m0_gnt_o}, 32'h0);
    @(negedge clk_i);
    checkOutput("ld_idle_busy", {31'h0, busy_o}, 32'h0);
    checkOutput("ld_idle_addr", lsu_addr_o, 32'h0);

    // m1 store 0xA5 to io_ledr
    applyStimulus(1, 1, 32'h880, 32'hA5, 1);
    sb.push_back('{port: 1'b1, data: 32'h0});
    @(negedge clk_i);
    checkOutput("st_gnt1",  {31'h0, m1_gnt_o}, 32'h1);
    checkOutput("st_st_en", {31'h0, lsu_st_en_o}, 32'h1);
    checkOutput("st_addr",  lsu_addr_o, 32'h880);
    checkOutput("st_data",  lsu_st_data_o, 32'hA5);
    applyStimulus(1, 0, 32'h880, 32'hA5, 1);
    @(negedge clk_i);
    checkOutput("st_ledr",       ioLedr, 32'hA5);
    checkOutput("st_en_resp",    {31'h0, lsu_st_en_o}, 32'h0);
    checkOutput("st_data_resp",  lsu_st_data_o, 32'h0);
    @(negedge clk_i);
    checkOutput("st_en_idle",    {31'h0, lsu_st_en_o}, 32'h0);
    checkOutput("st_busy_idle",  {31'h0, busy_o}, 32'h0);

    // Both ports request continuously from reset: m0, m1, m0, m1
    rst_ni = 1'b0;
    applyStimulus(0, 1, 32'h40, 32'h0, 0);
    applyStimulus(1, 1, 32'h44, 32'h0, 0);
    sb.push_back('{port: 1'b0, data: 32'h0000_4040});
    sb.push_back('{port: 1'b1, data: 32'h0000_4444});
    sb.push_back('{port: 1'b0, data: 32'h0000_4040});
    sb.push_back('{port: 1'b1, data: 32'h0000_4444});
    @(negedge clk_i);
    rst_ni = 1'b1;
    nG = 0;
    for (cyc = 0; cyc < 20 && nG < 4; cyc++) begin
      @(negedge clk_i);
      if (m0_gnt_o || m1_gnt_o) begin
        gPort[nG] = m1_gnt_o;
        gCyc[nG]  = cyc;
        nG++;
        if (nG == 4) begin
          applyStimulus(0, 0, 32'h40, 32'h0, 0);
          applyStimulus(1, 0, 32'h44, 32'h0, 0);
        end
      end
    end
    checkOutput("rr_count", nG, 32'd4);
    if (nG == 4) begin
      checkOutput("rr_first_cycle", gCyc[0], 32'd0);
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("rr_port%0d", i), {31'h0, gPort[i]}, (i % 2 == 1) ? 32'h1 : 32'h0);
        if (i > 0) checkOutput($sformatf("rr_spacing%0d", i), gCyc[i] - gCyc[i-1], 32'd2);
      end
    end
    repeat (2) @(negedge clk_i);
    checkOutput("rr_idle_busy", {31'h0, busy_o}, 32'h0);

    // m0 back-to-back; m1 joins mid-stream and must win the next arbitration
    applyStimulus(0, 1, 32'h10, 32'h0, 0);
    sb.push_back('{port: 1'b0, data: 32'hDEAD_BEEF});
    sb.push_back('{port: 1'b0, data: 32'hDEAD_BEEF});
    sb.push_back('{port: 1'b1, data: 32'h0000_4444});
    g0 = 0; raised = 0; raiseCyc = 0; m1GntCyc = -1;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk_i);
      if (m1_gnt_o) begin
        m1GntCyc = cyc;
        applyStimulus(0, 0, 32'h10, 32'h0, 0);
        applyStimulus(1, 0, 32'h44, 32'h0, 0);
        break;
      end
      if (m0_gnt_o) g0++;
      if (g0 == 2 && !raised) begin
        applyStimulus(1, 1, 32'h44, 32'h0, 0);
        raised   = 1;
        raiseCyc = cyc;
      end
    end
    checkOutput("mid_m0_gnts", g0, 32'd2);
    checkOutput("mid_m1_latency", m1GntCyc - raiseCyc, 32'd2);
    repeat (2) @(negedge clk_i);

    // Reset during the ACCESS cycle of a store to 0x20
    applyStimulus(0, 1, 32'h20, 32'hCAFE_F00D, 1);
    @(negedge clk_i);
    checkOutput("rsta_gnt0",  {31'h0, m0_gnt_o}, 32'h1);
    checkOutput("rsta_st_en", {31'h0, lsu_st_en_o}, 32'h1);
    rst_ni = 1'b0;
    #1;
    checkOutput("rsta_gnt",     {30'h0, m1_gnt_o, m0_gnt_o}, 32'h0);
    checkOutput("rsta_busy",    {31'h0, busy_o}, 32'h0);
    checkOutput("rsta_addr",    lsu_addr_o, 32'h0);
    checkOutput("rsta_st_en0",  {31'h0, lsu_st_en_o}, 32'h0);
    checkOutput("rsta_st_data", lsu_st_data_o, 32'h0);
    applyStimulus(0, 0, 32'h20, 32'hCAFE_F00D, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checkOutput("rsta_no_rvalid", {30'h0, m1_rvalid_o, m0_rvalid_o}, 32'h0);
    end
    checkOutput("rsta_mem20", mem[8], 32'h1234_5678);
    rst_ni = 1'b1;

    // Quiet period
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      checkOutput("quiet", {busy_o, lsu_st_en_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, lsu_addr_o[25:0]},
                  32'h0);
    end

    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/lsu_arbiter.md
# lsu_arbiter

Two-port arbiter and sequencer in front of the load-store unit. It shares the LSU's single address/store port between the core data port (m0) and a debug/DMA port (m1) using round-robin arbitration. It drives each access through the LSU's one-cycle registered load path and returns load data to the winning requester with a valid strobe. It sits between the requesters and the LSU and is the only block that drives the LSU's address, store-data and store-enable inputs.

## Interface
- IDLE_ADDR, 32'h0000_0000, address driven to the LSU when no access is in flight; must decode to data memory, never to an I/O register.
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low; clock clk_i
- m0_req_i / m1_req_i  in  1  access request; level, sampled at posedge
- m0_addr_i / m1_addr_i  in  32  byte address
- m0_wdata_i / m1_wdata_i  in  32  store data
- m0_we_i / m1_we_i  in  1  1 = store, 0 = load
- m0_gnt_o / m1_gnt_o  out  1  request accepted; one-cycle pulse in ACCESS
- m0_rvalid_o / m1_rvalid_o  out  1  access complete; one-cycle pulse in RESP
- m0_rdata_o / m1_rdata_o  out  32  load data; valid with rvalid
- lsu_addr_o  out  32  LSU address
- lsu_st_data_o  out  32  LSU store data
- lsu_st_en_o  out  1  LSU store enable
- lsu_ld_data_i  in  32  LSU registered load data
- busy_o  out  1  high in ACCESS or RESP

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE: if any req is high at the posedge, arbitrate, capture the winner's addr/wdata/we and id into registers, and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: lsu_addr_o, lsu_st_data_o and lsu_st_en_o come from the captured registers. gnt_o of the winner is 1. Always go to RESP.
- RESP: winner's rvalid_o = 1. For a load, winner's rdata_o = lsu_ld_data_i; for a store, rdata_o = 0. At the posedge the FSM arbitrates exactly as in IDLE: if any req is high, capture and go to ACCESS; otherwise go to IDLE.
- Outside ACCESS: lsu_addr_o = IDLE_ADDR, lsu_st_en_o = 0, lsu_st_data_o = 0. This prevents the LSU from writing I/O registers when no access is in flight.
- Round-robin: a last_winner register (reset value 1) tracks the most recent winner.
  - Both requesting: the port other than last_winner wins.
  - One requesting: that port wins.
  - last_winner updates on every capture.
- Requester rules:
  - Hold req, addr, wdata and we stable until gnt is seen.
  - Drop req at the posedge that ends the gnt cycle, unless a new access is wanted.
  - A req still high during RESP is a new request.
- Non-winner gnt/rvalid are 0 and its rdata is 0 at all times.
- Address, data and width pass through unmodified: no alignment checks and no byte enables. Only full 32-bit words are transferred.

## Timing
- Reset (async assert): state = IDLE, last_winner = 1, captured regs = 0.
  - All gnt/rvalid/rdata = 0, busy_o = 0.
  - lsu_addr_o = IDLE_ADDR, lsu_st_en_o = 0, lsu_st_data_o = 0.
- Reset mid-ACCESS or mid-RESP: the in-flight access is dropped and no rvalid is issued.
  - If reset asserts during ACCESS before the LSU edge, the store does not occur.
- Reset release: the first arbitration happens at the first posedge with rst_ni high.
- Latency: req high at edge E0 (IDLE) → gnt during cycle E0..E1 → LSU acts at E1 → rvalid/rdata during E1..E2.
- Throughput: back-to-back accesses take 2 cycles each (RESP → ACCESS directly).
- Simultaneous requests on both ports resolve in the same cycle; the loser waits one access (2 cycles) at most.
- gnt and rvalid are each asserted for exactly one cycle per access and are never asserted together.

## Test plan
- m0 load, addr 0x10, memory word 0xDEADBEEF:
  - lsu_addr_o = 0x10 and m0_gnt_o = 1 for one cycle.
  - Next cycle m0_rvalid_o = 1 with m0_rdata_o = 0xDEADBEEF.
  - Then busy_o = 0 and lsu_addr_o = IDLE_ADDR.
- m1 store 0x0000_00A5 to addr 0x880:
  - lsu_st_en_o = 1 only in ACCESS; LSU io_ledr = 0xA5 after the edge.
  - m1_rvalid_o = 1 with m1_rdata_o = 0.
  - lsu_st_en_o = 0 in every other cycle.
- Both ports request continuously from reset: grant order m0, m1, m0, m1, with gnts exactly 2 cycles apart and no port granted twice in a row.
- m0 requests back-to-back, m1 raises req mid-stream: m1 is granted at the next arbitration point, within 2 cycles.
- rst_ni pulsed low during ACCESS of a store to addr 0x20: no rvalid, memory at 0x20 unchanged, and all outputs return to reset values immediately.
- No requests for 10 cycles: busy_o = 0, lsu_st_en_o = 0, lsu_addr_o = IDLE_ADDR, and all gnt/rvalid = 0 throughout.
